// File: rtl/tblink_rpc_rvmux.sv
// tblink_rpc_rvmux: merges a local packet stream (port A, header-less) and a
// pass-through packet stream (port P, header included) onto one 8-bit network
// output. Packets are never interleaved; the grant alternates between the two
// ports whenever both have a packet waiting at a packet boundary.
//
// Handshake: a byte moves on any cycle where valid && ready are both high.
// Sources hold valid and data stable until that cycle. The mux holds no data;
// outputs are a combinational function of state/sel_a and the inputs.
module tblink_rpc_rvmux #(
  parameter logic [7:0] HDR = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] ia_dat,
  input  logic       ia_valid,
  output logic       ia_ready,
  input  logic [7:0] ip_dat,
  input  logic       ip_valid,
  output logic       ip_ready,
  output logic [7:0] o_dat,
  output logic       o_valid,
  input  logic       o_ready,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_HDR  = 2'b01,
    ST_CNT  = 2'b10,
    ST_DATA = 2'b11
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic       sel_a;
  logic       sel_a_nxt;
  logic       last_a;
  logic       last_a_nxt;
  logic [7:0] count;
  logic [7:0] count_nxt;
  logic [7:0] sel_dat;
  logic       sel_valid;

  // Granted port's data/valid, used once the header has gone out.
  assign sel_dat   = sel_a ? ia_dat : ip_dat;
  assign sel_valid = sel_a ? ia_valid : ip_valid;
  assign state_dbg = state;

  // State, grant and payload counter registers; reset abandons any packet.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= ST_IDLE;
      sel_a  <= 1'b0;
      last_a <= 1'b0;
      count  <= 8'h00;
    end else begin
      state  <= state_nxt;
      sel_a  <= sel_a_nxt;
      last_a <= last_a_nxt;
      count  <= count_nxt;
    end
  end

  // Arbitration, packet framing and the combinational pass-through.
  always_comb begin
    state_nxt  = state;
    sel_a_nxt  = sel_a;
    last_a_nxt = last_a;
    count_nxt  = count;
    o_dat      = 8'h00;
    o_valid    = 1'b0;
    ia_ready   = 1'b0;
    ip_ready   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Nothing moves here; this is the bubble between packets.
        if (ia_valid && ip_valid) begin
          // Both waiting: the port that did not win last time goes next.
          sel_a_nxt  = !last_a;
          last_a_nxt = !last_a;
          state_nxt  = ST_HDR;
        end else if (ia_valid) begin
          sel_a_nxt  = 1'b1;
          last_a_nxt = 1'b1;
          state_nxt  = ST_HDR;
        end else if (ip_valid) begin
          sel_a_nxt  = 1'b0;
          last_a_nxt = 1'b0;
          state_nxt  = ST_HDR;
        end
      end
      ST_HDR: begin
        if (sel_a) begin
          // Port A has no header of its own: the mux sources it.
          o_dat   = HDR;
          o_valid = 1'b1;
          if (o_ready) state_nxt = ST_CNT;
        end else begin
          o_dat    = ip_dat;
          o_valid  = ip_valid;
          ip_ready = o_ready;
          if (ip_valid && o_ready) state_nxt = ST_CNT;
        end
      end
      ST_CNT, ST_DATA: begin
        o_dat    = sel_dat;
        o_valid  = sel_valid;
        ia_ready = sel_a && o_ready;
        ip_ready = !sel_a && o_ready;
        if (sel_valid && o_ready) begin
          if (state == ST_CNT) begin
            // Count byte N announces N+1 payload bytes.
            count_nxt = sel_dat;
            state_nxt = ST_DATA;
          end else if (count == 8'h00) begin
            state_nxt = ST_IDLE;
          end else begin
            count_nxt = count - 8'h01;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_tblink_rpc_rvmux.sv
// Bench for tblink_rpc_rvmux. A packet-level reference model watches the
// source valids at each packet boundary, decides the winner with round-robin,
// and queues the whole expected output packet in exp_q. Every cycle it checks
// valid/ready on all three ports and pops exp_q on each output transfer.
module tb_tblink_rpc_rvmux;

  localparam logic [7:0] HDR = 8'h00;

  logic       clock;
  logic       reset;
  logic [7:0] ia_dat;
  logic       ia_valid;
  logic       ia_ready;
  logic [7:0] ip_dat;
  logic       ip_valid;
  logic       ip_ready;
  logic [7:0] o_dat;
  logic       o_valid;
  logic       o_ready;
  logic [1:0] state_dbg;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] src_a_q[$];
  logic [7:0] src_p_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] out_log[$];
  logic [7:0] exp_log[$];

  bit m_busy;
  bit m_sel_a;
  bit m_last_a;
  bit m_first;
  int m_left;
  bit chk_en   = 1'b1;
  int gap_pct  = 0;
  int rdy_mode = 0;

  tblink_rpc_rvmux #(.HDR(HDR)) dut (
    .clock    (clock),
    .reset    (reset),
    .ia_dat   (ia_dat),
    .ia_valid (ia_valid),
    .ia_ready (ia_ready),
    .ip_dat   (ip_dat),
    .ip_valid (ip_valid),
    .ip_ready (ip_ready),
    .o_dat    (o_dat),
    .o_valid  (o_valid),
    .o_ready  (o_ready),
    .state_dbg(state_dbg)
  );

  // Clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy   = 1'b0;
    m_sel_a  = 1'b0;
    m_last_a = 1'b0;
    m_first  = 1'b0;
    m_left   = 0;
    exp_q.delete();
  endtask

  // One cycle of the packet-level model, evaluated mid-cycle.
  task automatic model_step();
    bit         win_a;
    bit         exp_v;
    int         n;
    logic [7:0] b;
    if (!m_busy) begin
      check("idle_o_valid", o_valid, 0);
      check("idle_ia_ready", ia_ready, 0);
      check("idle_ip_ready", ip_ready, 0);
      if (ia_valid || ip_valid) begin
        win_a = (ia_valid && ip_valid) ? !m_last_a : ia_valid;
        if ((win_a && src_a_q.size() < 1) || (!win_a && src_p_q.size() < 2)) begin
          n_tests++;
          n_fail++;
          $display("FAIL grant_source: no queued packet for winner %0d", win_a);
        end else begin
          m_last_a = win_a;
          m_sel_a  = win_a;
          m_busy   = 1'b1;
          m_first  = 1'b1;
          if (win_a) begin
            n = int'(src_a_q[0]);
            exp_q.push_back(HDR);
            for (int i = 0; i < n + 2; i++) exp_q.push_back(src_a_q.pop_front());
          end else begin
            n = int'(src_p_q[1]);
            for (int i = 0; i < n + 3; i++) exp_q.push_back(src_p_q.pop_front());
          end
          m_left = n + 3;
        end
      end
    end else begin
      exp_v = (m_sel_a && m_first) ? 1'b1 : (m_sel_a ? ia_valid : ip_valid);
      check("o_valid", o_valid, exp_v);
      check("ia_ready", ia_ready, (m_sel_a && !m_first) ? o_ready : 1'b0);
      check("ip_ready", ip_ready, !m_sel_a ? o_ready : 1'b0);
      if (o_valid && o_ready) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL o_extra_byte: got %0h, expected no byte", o_dat);
        end else begin
          b = exp_q.pop_front();
          check("o_dat", o_dat, b);
        end
        out_log.push_back(o_dat);
        m_first = 1'b0;
        m_left--;
        if (m_left == 0) m_busy = 1'b0;
      end
    end
  endtask

  // Scoreboard/compare process on the falling edge.
  initial begin
    model_reset();
    forever begin
      @(negedge clock);
      if (reset) model_reset();
      else if (chk_en) model_step();
    end
  end

  // Output ready pattern: 0 = always ready, 1 = toggle, 2 = random 70%.
  initial begin
    o_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      case (rdy_mode)
        0:       o_ready = 1'b1;
        1:       o_ready = !o_ready;
        default: o_ready = (int'($urandom_range(99)) < 70);
      endcase
    end
  end

  // Send one packet on port A (count + payload) or P (hdr + count + payload).
  // Payload byte i is base + step*i. Called and returns at posedge+1.
  task automatic drive_pkt(input bit port_a, input logic [7:0] hdr, input logic [7:0] cnt,
                           input logic [7:0] base, input logic [7:0] step);
    logic [7:0] q[$];
    bit hs;
    int t;
    if (!port_a) q.push_back(hdr);
    q.push_back(cnt);
    for (int i = 0; i <= int'(cnt); i++) q.push_back(base + step * 8'(i));
    foreach (q[i]) begin
      if (port_a) src_a_q.push_back(q[i]);
      else src_p_q.push_back(q[i]);
    end
    foreach (q[i]) begin
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
        if (port_a) ia_valid = 1'b0;
        else ip_valid = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clock);
        #1;
      end
      if (port_a) begin
        ia_valid = 1'b1;
        ia_dat   = q[i];
      end else begin
        ip_valid = 1'b1;
        ip_dat   = q[i];
      end
      t = 0;
      forever begin
        @(negedge clock);
        hs = port_a ? ia_ready : ip_ready;
        @(posedge clock);
        #1;
        if (hs) break;
        t++;
        if (t > 3000) begin
          n_tests++;
          n_fail++;
          $display("FAIL drive_timeout: port_a=%0d byte %0d never accepted", port_a, i);
          break;
        end
      end
    end
    if (port_a) ia_valid = 1'b0;
    else ip_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t = 0;
    repeat (2) @(posedge clock);
    while ((m_busy || exp_q.size() != 0) && t < 5000) begin
      @(posedge clock);
      t++;
    end
    if (t >= 5000) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_idle: model still busy after %0d cycles", t);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic check_log(input string name);
    check({name, "_len"}, out_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < out_log.size(); i++)
      check($sformatf("%s_b%0d", name, i), out_log[i], exp_log[i]);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  // Test sequence
  initial begin
    reset    = 1'b1;
    ia_dat   = 8'h00;
    ia_valid = 1'b1;
    ip_dat   = 8'h00;
    ip_valid = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("rst_o_valid", o_valid, 0);
    check("rst_ia_ready", ia_ready, 0);
    check("rst_ip_ready", ip_ready, 0);
    check("rst_state", state_dbg, 2'b00);
    ia_valid = 1'b0;
    ip_valid = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock);
    #1;

    // Single A packet
    out_log.delete();
    drive_pkt(1'b1, 8'h00, 8'h02, 8'h11, 8'h11);
    wait_idle();
    exp_log = '{8'h00, 8'h02, 8'h11, 8'h22, 8'h33};
    check_log("single_a");

    // Single P packet
    out_log.delete();
    drive_pkt(1'b0, 8'h05, 8'h00, 8'hAA, 8'h00);
    wait_idle();
    exp_log = '{8'h05, 8'h00, 8'hAA};
    check_log("single_p");

    // Both ports valid straight out of reset: A, P, then A wins the next tie
    pulse_reset();
    out_log.delete();
    fork
      begin
        drive_pkt(1'b1, 8'h00, 8'h00, 8'hA1, 8'h00);
        drive_pkt(1'b1, 8'h00, 8'h00, 8'hA2, 8'h00);
      end
      begin
        drive_pkt(1'b0, 8'h7E, 8'h00, 8'hB1, 8'h00);
        drive_pkt(1'b0, 8'h7E, 8'h00, 8'hB2, 8'h00);
      end
    join
    wait_idle();
    exp_log = '{8'h00, 8'h00, 8'hA1, 8'h7E, 8'h00, 8'hB1,
                8'h00, 8'h00, 8'hA2, 8'h7E, 8'h00, 8'hB2};
    check_log("tie_rr");

    // Output back-pressure toggling every cycle during an N=3 A packet
    rdy_mode = 1;
    out_log.delete();
    drive_pkt(1'b1, 8'h00, 8'h03, 8'h10, 8'h01);
    wait_idle();
    rdy_mode = 0;
    exp_log = '{8'h00, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13};
    check_log("stall_a");

    // Maximum-length P packet: 256 payload bytes
    out_log.delete();
    drive_pkt(1'b0, 8'h42, 8'hFF, 8'h00, 8'h01);
    wait_idle();
    check("max_len", out_log.size(), 258);
    check("max_hdr", out_log[0], 8'h42);
    check("max_cnt", out_log[1], 8'hFF);
    check("max_first", out_log[2], 8'h00);
    check("max_last", out_log[257], 8'hFF);
    check("max_state", state_dbg, 2'b00);

    // Randomised traffic on both ports with gaps and random back-pressure
    gap_pct  = 25;
    rdy_mode = 2;
    fork
      for (int k = 0; k < 15; k++)
        drive_pkt(1'b1, 8'h00, 8'($urandom_range(0, 12)), 8'($urandom_range(0, 255)),
                  8'($urandom_range(0, 255)));
      for (int k = 0; k < 15; k++)
        drive_pkt(1'b0, 8'($urandom_range(0, 127)), 8'($urandom_range(0, 12)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    join
    wait_idle();
    check("rand_drained", exp_q.size(), 0);
    gap_pct  = 0;
    rdy_mode = 0;
    @(posedge clock);
    #1;

    // Reset in the middle of an A packet's payload
    chk_en   = 1'b0;
    ia_valid = 1'b1;
    ia_dat   = 8'h05;
    repeat (3) @(posedge clock);
    #1;
    ia_dat = 8'h40;
    @(negedge clock);
    check("mid_state", state_dbg, 2'b11);
    check("mid_o_valid", o_valid, 1);
    check("mid_o_dat", o_dat, 8'h40);
    reset = 1'b1;
    #1;
    check("arst_o_valid", o_valid, 0);
    check("arst_ia_ready", ia_ready, 0);
    check("arst_ip_ready", ip_ready, 0);
    check("arst_state", state_dbg, 2'b00);
    ia_valid = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;
    out_log.delete();
    drive_pkt(1'b0, 8'h33, 8'h01, 8'hC1, 8'h01);
    wait_idle();
    exp_log = '{8'h33, 8'h01, 8'hC1, 8'hC2};
    check_log("after_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
